// File: rtl/ps2_scancode_decoder.sv
// Turns the PS/2 receive byte stream into key make/break events and tracks
// the held state of the eight game-control keys.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no prefix pending; next byte starts a new sequence
// GOT_E0   | extended prefix seen, waiting for code or F0
// GOT_F0   | break prefix seen, waiting for code
// GOT_E0F0 | extended break prefix seen, waiting for code
// SKIP     | swallowing the tail of the Pause sequence
module ps2_scancode_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 2_500_000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  output logic       key_event,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_released,
  output logic [7:0] keys_held
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

  localparam logic [7:0] BYTE_E0 = 8'hE0;
  localparam logic [7:0] BYTE_F0 = 8'hF0;
  localparam logic [7:0] BYTE_E1 = 8'hE1;

  typedef enum logic [2:0] {
    IDLE,
    GOT_E0,
    GOT_F0,
    GOT_E0F0,
    SKIP
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [2:0]       skip_cnt;
  logic [2:0]       skip_nxt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_expired;

  logic             ev;
  logic             ev_ext;
  logic             ev_rel;
  logic [7:0]       ev_mask;

  // Keyboard housekeeping replies (ACK, BAT ok, echo, resend, errors).
  function automatic logic is_filtered(input logic [7:0] b);
    return (b == 8'hFA) || (b == 8'hAA) || (b == 8'hEE) ||
           (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
  endfunction

  function automatic logic [7:0] key_mask(input logic [7:0] code, input logic ext);
    logic [7:0] m;
    m = 8'h00;
    if (!ext) begin
      case (code)
        8'h1D:   m[0] = 1'b1;
        8'h1C:   m[1] = 1'b1;
        8'h1B:   m[2] = 1'b1;
        8'h23:   m[3] = 1'b1;
        default: m = 8'h00;
      endcase
    end else begin
      case (code)
        8'h75:   m[4] = 1'b1;
        8'h6B:   m[5] = 1'b1;
        8'h72:   m[6] = 1'b1;
        8'h74:   m[7] = 1'b1;
        default: m = 8'h00;
      endcase
    end
    return m;
  endfunction

  assign tmo_expired = (tmo_cnt >= TMO_LIMIT);

  always_comb begin
    state_nxt = state;
    skip_nxt  = skip_cnt;
    ev        = 1'b0;
    ev_ext    = 1'b0;
    ev_rel    = 1'b0;
    if (received_data_en) begin
      if (state == SKIP) begin
        if (skip_cnt <= 3'd1) begin
          state_nxt = IDLE;
          skip_nxt  = 3'd0;
        end else begin
          skip_nxt = skip_cnt - 3'd1;
        end
      end else if (is_filtered(received_data)) begin
        state_nxt = IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (received_data == BYTE_E0) begin
              state_nxt = GOT_E0;
            end else if (received_data == BYTE_F0) begin
              state_nxt = GOT_F0;
            end else if (received_data == BYTE_E1) begin
              // Pause has no break code; report it once, drop the other 7 bytes.
              state_nxt = SKIP;
              skip_nxt  = 3'd7;
              ev        = 1'b1;
            end else begin
              ev = 1'b1;
            end
          end
          GOT_E0: begin
            if (received_data == BYTE_F0) begin
              state_nxt = GOT_E0F0;
            end else if (received_data != BYTE_E0) begin
              state_nxt = IDLE;
              ev        = 1'b1;
              ev_ext    = 1'b1;
            end
          end
          GOT_F0: begin
            if (received_data == BYTE_E0) begin
              state_nxt = GOT_E0;
            end else if (received_data != BYTE_F0) begin
              state_nxt = IDLE;
              ev        = 1'b1;
              ev_rel    = 1'b1;
            end
          end
          GOT_E0F0: begin
            if (received_data == BYTE_E0) begin
              state_nxt = GOT_E0;
            end else if (received_data == BYTE_F0) begin
              state_nxt = GOT_F0;
            end else begin
              state_nxt = IDLE;
              ev        = 1'b1;
              ev_ext    = 1'b1;
              ev_rel    = 1'b1;
            end
          end
          default: state_nxt = IDLE;
        endcase
      end
    end else if (state != IDLE && tmo_expired) begin
      state_nxt = IDLE;
      skip_nxt  = 3'd0;
    end
  end

  assign ev_mask = key_mask(received_data, ev_ext);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      skip_cnt     <= 3'd0;
      tmo_cnt      <= '0;
      key_event    <= 1'b0;
      key_code     <= 8'h00;
      key_extended <= 1'b0;
      key_released <= 1'b0;
      keys_held    <= 8'h00;
    end else begin
      state     <= state_nxt;
      skip_cnt  <= skip_nxt;
      key_event <= ev;

      // A strobe restarts the window; expiry and IDLE both park the counter at 0.
      if (received_data_en || state == IDLE || tmo_expired) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end

      if (ev) begin
        key_code     <= received_data;
        key_extended <= ev_ext;
        key_released <= ev_rel;
        if (ev_rel) begin
          keys_held <= keys_held & ~ev_mask;
        end else begin
          keys_held <= keys_held | ev_mask;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Scoreboard bench for ps2_scancode_decoder: a prefix-flag reference model
// queues expected events, a negedge monitor pops and compares them.
module tb_ps2_scancode_decoder;

  localparam int TMO = 100;

  logic       clk;
  logic       resetn;
  logic [7:0] data;
  logic       en;
  logic       key_event;
  logic [7:0] key_code;
  logic       key_extended;
  logic       key_released;
  logic [7:0] keys_held;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [7:0] code;
    logic       ext;
    logic       rel;
    logic [7:0] held;
    int         at;
  } exp_t;

  exp_t q[$];

  // reference model state
  logic       ext_p;
  logic       brk_p;
  int         skip_left;
  logic [7:0] held_m;
  int         last_cyc;
  logic [7:0] map_code [8];
  logic       map_ext  [8];

  ps2_scancode_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
    .CLOCK_50         (clk),
    .resetn           (resetn),
    .received_data    (data),
    .received_data_en (en),
    .key_event        (key_event),
    .key_code         (key_code),
    .key_extended     (key_extended),
    .key_released     (key_released),
    .keys_held        (keys_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic model_clear();
    ext_p     = 1'b0;
    brk_p     = 1'b0;
    skip_left = 0;
  endtask

  task automatic push_event(input logic [7:0] b, input int now);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      if (map_code[i] == b && map_ext[i] == ext_p) held_m[i] = !brk_p;
    end
    e.code = b;
    e.ext  = ext_p;
    e.rel  = brk_p;
    e.held = held_m;
    e.at   = now + 1;
    q.push_back(e);
  endtask

  task automatic model_byte(input logic [7:0] b, input int now);
    if (now - last_cyc - 1 > TMO) model_clear();
    last_cyc = now;
    if (skip_left > 0) begin
      skip_left--;
      return;
    end
    if (b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF}) begin
      model_clear();
      return;
    end
    if (b == 8'hE0) begin
      ext_p = 1'b1;
      brk_p = 1'b0;
      return;
    end
    if (b == 8'hF0) begin
      if (!(ext_p && !brk_p)) ext_p = 1'b0;
      brk_p = 1'b1;
      return;
    end
    if (b == 8'hE1 && !ext_p && !brk_p) begin
      push_event(b, now);
      skip_left = 7;
      return;
    end
    push_event(b, now);
    model_clear();
  endtask

  // Called at posedge+1; leaves at posedge+1 with the strobe removed.
  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    model_byte(b, cyc);
    data = b;
    en   = 1'b1;
    @(posedge clk);
    #1;
    en   = 1'b0;
    data = $urandom_range(0, 255);
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d events still outstanding, required 0", q.size());
      q.delete();
    end
  endtask

  always @(negedge clk) begin
    if (resetn && key_event) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event: code=%02h ext=%0d rel=%0d at cycle %0d, none expected",
                 key_code, key_extended, key_released, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (key_code !== e.code || key_extended !== e.ext || key_released !== e.rel ||
            keys_held !== e.held || cyc != e.at) begin
          failures++;
          $display("FAIL event: got code=%02h ext=%0d rel=%0d held=%02h cyc=%0d, required code=%02h ext=%0d rel=%0d held=%02h cyc=%0d",
                   key_code, key_extended, key_released, keys_held, cyc,
                   e.code, e.ext, e.rel, e.held, e.at);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] filt [6];
    logic [7:0] b;
    int r;
    int gap;

    map_code = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h75, 8'h6B, 8'h72, 8'h74};
    map_ext  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    filt     = '{8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
    model_clear();
    held_m   = 8'h00;
    last_cyc = 0;

    resetn = 1'b0;
    en     = 1'b0;
    data   = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({key_event, key_code, key_extended, key_released, keys_held} !== 19'd0) begin
      failures++;
      $display("FAIL reset_state: ev=%0d code=%02h ext=%0d rel=%0d held=%02h, required all 0",
               key_event, key_code, key_extended, key_released, keys_held);
    end
    resetn = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end

    // make / break
    send(8'h1D, 0);
    send(8'hF0, 2);
    send(8'h1D, 0);
    drain();

    // extended keys, then keypad 8 without E0
    send(8'hE0, 0); send(8'h75, 0);
    send(8'hE0, 1); send(8'h74, 0);
    send(8'hE0, 1); send(8'hF0, 0); send(8'h75, 0);
    send(8'h75, 1);
    drain();

    // pause sequence back-to-back, then filtered bytes
    send(8'hE1, 0); send(8'h14, 0); send(8'h77, 0); send(8'hE1, 0);
    send(8'hF0, 0); send(8'h14, 0); send(8'hF0, 0); send(8'h77, 0);
    send(8'hFA, 0); send(8'hAA, 0); send(8'h1C, 0);
    drain();

    // timeout abandons the break prefix
    send(8'hF0, 0);
    send(8'h1B, TMO + 5);
    // one cycle past the limit is also abandoned
    send(8'hF0, 0);
    send(8'h23, TMO + 1);
    // strobe coincides with expiry: byte wins
    send(8'hF0, 0);
    send(8'h23, TMO);
    drain();

    // async reset mid-sequence
    send(8'h1D, 0);
    send(8'hE0, 0);
    drain();
    #3;
    resetn = 1'b0;
    #1;
    checks++;
    if ({key_event, key_code, key_extended, key_released, keys_held} !== 19'd0) begin
      failures++;
      $display("FAIL async_reset: ev=%0d code=%02h ext=%0d rel=%0d held=%02h, required all 0",
               key_event, key_code, key_extended, key_released, keys_held);
    end
    model_clear();
    held_m = 8'h00;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    send(8'h6B, 1);
    drain();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0: b = 8'hE0;
        1: b = 8'hF0;
        2: b = ($urandom_range(0, 3) == 0) ? 8'hE1 : 8'h1D;
        3: b = filt[$urandom_range(0, 5)];
        4, 5, 6: b = map_code[$urandom_range(0, 7)];
        default: b = 8'($urandom_range(0, 255));
      endcase
      r = $urandom_range(0, 19);
      if (r < 12) gap = 0;
      else if (r < 18) gap = $urandom_range(1, 3);
      else if (r == 18) gap = TMO;
      else gap = $urandom_range(TMO + 1, TMO + 50);
      send(b, gap);
    end
    drain();

    checks++;
    if (keys_held !== held_m) begin
      failures++;
      $display("FAIL final_held: got %02h, required %02h", keys_held, held_m);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
